rsa_job_sched: RTL
==================

RSA_JOB_SCHED -- requirements
Module: rsa_job_sched

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 200000, watchdog limit in cycles from core start to core finish.
REQ-002 Parameter: TO_W, 18, watchdog counter width; TIMEOUT_CYCLES SHALL fit in TO_W bits.
REQ-003 Port: i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: i_rst  in  1  reset, synchronous, active-low.
REQ-005 Port: i_req_valid  in  2  per-requester job request (bit r = requester r).
REQ-006 Port: o_req_ready  out  2  per-requester job accept.
REQ-007 Port: i_a0, i_e0, i_n0  in  256 each  requester 0 operands (base, exponent, modulus).
REQ-008 Port: i_a1, i_e1, i_n1  in  256 each  requester 1 operands.
REQ-009 Port: o_rsp_valid  out  1  result available.
REQ-010 Port: i_rsp_ready  in  1  result consumer accept.
REQ-011 Port: o_rsp_id  out  1  requester index owning the result.
REQ-012 Port: o_rsp_data  out  256  a^e mod n from the core.
REQ-013 Port: o_rsp_err  out  1  job aborted by watchdog; o_rsp_data SHALL be 0.
REQ-014 Port: o_core_start  out  1  one-cycle start pulse to the shared Rsa256Core.
REQ-015 Port: o_core_a, o_core_e, o_core_n  out  256 each  latched operands to the core.
REQ-016 Port: i_core_finished  in  1  core done pulse.
REQ-017 Port: i_core_result  in  256  core result, valid with i_core_finished.
REQ-018 Port: o_core_rst  out  1  active-low reset to the core.
REQ-019 Port: o_busy  out  1  high in every state except S_IDLE.

Function
REQ-020 FSM states: S_IDLE, S_START, S_WAIT, S_RESP; exactly one job in flight.
REQ-021 S_IDLE: winner = requester with i_req_valid set; both set -> requester != last_grant wins; o_req_ready[winner]=1 combinationally, other bit 0.
REQ-022 Accept (valid&ready) in cycle T: latch winner operands into o_core_a/e/n, record id, update last_grant, enter S_START at T+1.
REQ-023 S_START: o_core_start=1 for exactly one cycle, then S_WAIT; watchdog counter cleared to 0.
REQ-024 S_WAIT: i_core_finished=1 -> latch i_core_result into o_rsp_data, o_rsp_err=0, enter S_RESP; o_rsp_valid rises the cycle after finish.
REQ-025 i_core_finished outside S_WAIT SHALL be ignored.
REQ-026 S_RESP: o_rsp_valid=1, o_rsp_id/data/err held stable until i_rsp_ready=1; then S_IDLE next cycle.
REQ-027 o_req_ready SHALL be 00 in every state except S_IDLE; operands SHALL not change after accept.
REQ-028 last_grant SHALL update only on accept; single requester wins regardless of last_grant.

Reset
REQ-029 i_rst=0 at a rising edge: state S_IDLE, last_grant=1 (requester 0 wins first tie), o_rsp_valid=0, o_rsp_err=0, o_rsp_id=0, o_rsp_data=0, o_core_a/e/n=0, o_core_start=0, watchdog=0, o_busy=0.
REQ-030 o_core_rst SHALL equal i_rst AND NOT abort_pulse; reset mid-job SHALL discard the job without response.
REQ-031 o_req_ready SHALL be 00 while i_rst=0.

Configuration
REQ-032 Macro RSA_SCHED_TIMEOUT_EN defined: in S_WAIT watchdog increments per cycle; reaching TIMEOUT_CYCLES without finish -> registered abort_pulse for one cycle (o_core_rst=0), o_rsp_err=1, o_rsp_data=0, enter S_RESP.
REQ-033 Finish and timeout in the same cycle: finish wins, err=0.
REQ-034 Macro undefined: no watchdog logic, o_rsp_err tied 0, o_core_rst equals i_rst, S_WAIT waits indefinitely.

Verification
REQ-035 Single job: req0 a=0x2,e=0x10,n=0x3B9ACA07, model finishes 50 cycles after start -> one start pulse at T+1, rsp_valid at finish+1, id=0, data=0x10000 (2^16), err=0.
REQ-036 Fairness: both valid continuously for 4 jobs after reset -> grant order 0,1,0,1; ready never 11.
REQ-037 Backpressure: i_rsp_ready low 20 cycles in S_RESP -> valid/data/id stable, ready=00, no new start.
REQ-038 Reset mid-S_WAIT: i_rst=0 one cycle at finish-10 -> S_IDLE, no response, later finish pulse ignored, o_core_rst=0 that cycle.
REQ-039 With RSA_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, core never finishes -> o_core_rst low one cycle, rsp_valid=1, err=1, data=0 at start+101.
REQ-040 Spurious i_core_finished in S_IDLE -> no state change, rsp_valid stays 0.

Source files
------------

// File: rtl/rsa_job_sched.sv
// Two-requester round-robin scheduler for one shared Rsa256Core; one job in flight at a time.
// Optional core watchdog is enabled by defining RSA_SCHED_TIMEOUT_EN.
module rsa_job_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned TO_W           = 18
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [1:0]   i_req_valid,
    output logic [1:0]   o_req_ready,
    input  logic [255:0] i_a0,
    input  logic [255:0] i_e0,
    input  logic [255:0] i_n0,
    input  logic [255:0] i_a1,
    input  logic [255:0] i_e1,
    input  logic [255:0] i_n1,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic         o_rsp_id,
    output logic [255:0] o_rsp_data,
    output logic         o_rsp_err,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_e,
    output logic [255:0] o_core_n,
    input  logic         i_core_finished,
    input  logic [255:0] i_core_result,
    output logic         o_core_rst,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   winner;
    logic   accept;
    logic   core_done;
    logic   timeout_hit;

    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W)) begin : g_timeout_range
        $error("TIMEOUT_CYCLES does not fit in TO_W bits");
    end

    // On a tie the requester that did not win last time is served.
    always_comb begin
        winner = 1'b0;
        case (i_req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
    end

    assign accept    = |(i_req_valid & o_req_ready);
    assign core_done = (state == S_WAIT) && i_core_finished;

`ifdef RSA_SCHED_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] wd_cnt;
    logic            abort_pulse;

    // Finish has priority over an expiring watchdog in the same cycle.
    assign timeout_hit = (state == S_WAIT) && !i_core_finished && (wd_cnt == TO_LIMIT);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wd_cnt      <= '0;
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= timeout_hit;
            if (state == S_START) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + TO_W'(1);
            end
        end
    end

    assign o_core_rst = i_rst & ~abort_pulse;
`else
    assign timeout_hit = 1'b0;
    assign o_core_rst  = i_rst;
    assign o_rsp_err   = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (core_done || timeout_hit) state_nxt = S_RESP;
            S_RESP:  if (i_rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = '0;
        o_core_start = 1'b0;
        o_rsp_valid  = 1'b0;
        o_busy       = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_rst) begin
                    o_req_ready[winner] = i_req_valid[winner];
                end
            end
            S_START: o_core_start = 1'b1;
            S_WAIT:  ;
            S_RESP:  o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            last_grant <= 1'b1;
            o_rsp_id   <= 1'b0;
            o_rsp_data <= '0;
            o_core_a   <= '0;
            o_core_e   <= '0;
            o_core_n   <= '0;
        end else begin
            if (accept) begin
                last_grant <= winner;
                o_rsp_id   <= winner;
                o_core_a   <= winner ? i_a1 : i_a0;
                o_core_e   <= winner ? i_e1 : i_e0;
                o_core_n   <= winner ? i_n1 : i_n0;
            end
            if (core_done) begin
                o_rsp_data <= i_core_result;
            end else if (timeout_hit) begin
                o_rsp_data <= '0;
            end
        end
    end

`ifdef RSA_SCHED_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_rsp_err <= 1'b0;
        end else if (core_done) begin
            o_rsp_err <= 1'b0;
        end else if (timeout_hit) begin
            o_rsp_err <= 1'b1;
        end
    end
`endif

endmodule
